// File: rtl/lj24rx.sv
// lj24rx: left-justified serial audio receiver (slave).
//
// Samples the external lrck/bck/data lines in the clk domain, deserialises one sample per
// lrck half-period (MSB first, first bck rise after the lrck edge carries the MSB) and
// issues one write per channel to a downstream FIFO.
//
// Ports:
//   clk, reset_n         system clock, synchronous active-low reset
//   lrck, bck, data      serial port inputs, asynchronous to clk
//   fifo_full            downstream FIFO full; sampled only in the push cycle
//   fifo_wrreq           one-clk write strobe
//   fifo_data            {ch, 7'd0, sample[23:0]}, ch=1 for left, sample left-aligned
//   frame_err            sticky: lrck edge arrived before DATA_W bits were captured
//   ovf                  sticky: word dropped because fifo_full
//   err_clr              clears frame_err/ovf (and drop_cnt) on the next clk
//   drop_cnt             (LJ24RX_DROP_CNT_EN only) saturating count of dropped words
//
// Optional feature macro: LJ24RX_DROP_CNT_EN adds the drop_cnt output and its counter.
module lj24rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DATA_W      = 24,
  parameter logic        LEFT_LVL    = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        lrck,
  input  logic        bck,
  input  logic        data,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [31:0] fifo_data,
  output logic        frame_err,
  output logic        ovf,
  input  logic        err_clr
`ifdef LJ24RX_DROP_CNT_EN
  ,
  output logic [7:0]  drop_cnt
`endif
);

  localparam int unsigned CntW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [1:0] StAlign = 2'd0;
  localparam logic [1:0] StShift = 2'd1;
  localparam logic [1:0] StPush  = 2'd2;
  localparam logic [1:0] StWait  = 2'd3;

  logic [SYNC_STAGES-1:0] lrck_sync_q, lrck_sync_d;
  logic [SYNC_STAGES-1:0] bck_sync_q, bck_sync_d;
  logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
  logic [SYNC_STAGES:0]   prime_q, prime_d;
  logic                   lrck_prev_q, bck_prev_q;
  logic [1:0]             state_q, state_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_W-1:0]      sreg_q, sreg_d;
  logic                   ch_q, ch_d;
  logic                   wrreq_q, wrreq_d;
  logic [31:0]            fdata_q, fdata_d;
  logic                   frame_err_q, frame_err_d;
  logic                   ovf_q, ovf_d;

  logic        lrck_s, bck_s, data_s, primed, lrck_edge, bck_rise;
  logic [23:0] sample;

  assign lrck_s = lrck_sync_q[SYNC_STAGES-1];
  assign bck_s  = bck_sync_q[SYNC_STAGES-1];
  assign data_s = data_sync_q[SYNC_STAGES-1];

  // The sync chains and edge registers come out of reset as 0; edges are ignored until
  // both the synced value and its previous copy reflect the real line, so a line that
  // is simply high at reset release is not mistaken for an edge.
  assign primed    = prime_q[SYNC_STAGES];
  assign lrck_edge = primed && (lrck_s != lrck_prev_q);
  assign bck_rise  = primed && bck_s && !bck_prev_q;

  assign sample = 24'(sreg_q) << (24 - DATA_W);

  always_comb begin
    lrck_sync_d = {lrck_sync_q[SYNC_STAGES-2:0], lrck};
    bck_sync_d  = {bck_sync_q[SYNC_STAGES-2:0], bck};
    data_sync_d = {data_sync_q[SYNC_STAGES-2:0], data};
    prime_d     = {prime_q[SYNC_STAGES-1:0], 1'b1};

    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    sreg_d      = sreg_q;
    ch_d        = ch_q;
    wrreq_d     = 1'b0;
    fdata_d     = fdata_q;
    frame_err_d = frame_err_q & ~err_clr;
    ovf_d       = ovf_q & ~err_clr;

    if (state_q == StPush) begin
      if (fifo_full) begin
        ovf_d = 1'b1;
      end else begin
        wrreq_d = 1'b1;
        fdata_d = {ch_q, 7'd0, sample};
      end
      state_d = StWait;
    end

    // An lrck edge always opens a new frame; in PUSH the word above still completes.
    if (lrck_edge) begin
      if (state_q == StShift) frame_err_d = 1'b1;
      state_d   = StShift;
      bit_cnt_d = '0;
      sreg_d    = '0;
      ch_d      = (lrck_s == LEFT_LVL);
    end

    // A bck rise coinciding with the lrck edge is the MSB of the new frame.
    if (bck_rise && (state_d == StShift)) begin
      sreg_d = (sreg_d << 1) | DATA_W'(data_s);
      if (bit_cnt_d == CntW'(DATA_W - 1)) begin
        state_d   = StPush;
        bit_cnt_d = '0;
      end else begin
        bit_cnt_d = bit_cnt_d + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lrck_sync_q <= '0;
      bck_sync_q  <= '0;
      data_sync_q <= '0;
      prime_q     <= '0;
      lrck_prev_q <= 1'b0;
      bck_prev_q  <= 1'b0;
      state_q     <= StAlign;
      bit_cnt_q   <= '0;
      sreg_q      <= '0;
      ch_q        <= 1'b0;
      wrreq_q     <= 1'b0;
      fdata_q     <= '0;
      frame_err_q <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      lrck_sync_q <= lrck_sync_d;
      bck_sync_q  <= bck_sync_d;
      data_sync_q <= data_sync_d;
      prime_q     <= prime_d;
      lrck_prev_q <= lrck_s;
      bck_prev_q  <= bck_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      sreg_q      <= sreg_d;
      ch_q        <= ch_d;
      wrreq_q     <= wrreq_d;
      fdata_q     <= fdata_d;
      frame_err_q <= frame_err_d;
      ovf_q       <= ovf_d;
    end
  end

  assign fifo_wrreq = wrreq_q;
  assign fifo_data  = fdata_q;
  assign frame_err  = frame_err_q;
  assign ovf        = ovf_q;

`ifdef LJ24RX_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic       drop_inc;

  assign drop_inc = (state_q == StPush) && fifo_full;

  // A drop in the same cycle as err_clr survives as a count of one.
  always_comb begin
    drop_cnt_d = err_clr ? 8'd0 : drop_cnt_q;
    if (drop_inc) begin
      if (err_clr)                  drop_cnt_d = 8'd1;
      else if (drop_cnt_q != 8'hFF) drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) drop_cnt_q <= 8'd0;
    else          drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_lj24rx.sv
// Directed testbench for lj24rx: drives a left-justified 64fs serial stream (bck = 4 clk)
// and checks written words, latency, sticky flags and reset behaviour.
// Build with LJ24RX_DROP_CNT_EN defined to also exercise drop_cnt.
module tb_lj24rx;
  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        lrck = 1'b1;
  logic        bck = 1'b0;
  logic        data = 1'b0;
  logic        fifo_full = 1'b0;
  logic        err_clr = 1'b0;
  logic        fifo_wrreq;
  logic [31:0] fifo_data;
  logic        frame_err;
  logic        ovf;
`ifdef LJ24RX_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  int          checks = 0;
  int          passed = 0;
  int          cyc = 0;
  int          wr_cnt = 0;
  int          last_wr_cyc = 0;
  int          rise_cyc = 0;
  int          base;
  logic        prev_wr = 1'b0;
  logic        double_wr = 1'b0;
  logic [31:0] wq[$];
  logic [31:0] eq[$];

  localparam logic [23:0] WL = 24'hABCDEF;
  localparam logic [23:0] WR = 24'h123456;

  lj24rx dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .lrck      (lrck),
    .bck       (bck),
    .data      (data),
    .fifo_full (fifo_full),
    .fifo_wrreq(fifo_wrreq),
    .fifo_data (fifo_data),
    .frame_err (frame_err),
    .ovf       (ovf),
    .err_clr   (err_clr)
`ifdef LJ24RX_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (fifo_wrreq) begin
      wq.push_back(fifo_data);
      wr_cnt++;
      last_wr_cyc = cyc;
      if (prev_wr) double_wr = 1'b1;
    end
    prev_wr = fifo_wrreq;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    logic [31:0] obs;
    obs = (wq.size() > 0) ? wq.pop_front() : 32'hxxxxxxxx;
    check(tag, obs, exp);
  endtask

  // Bits start..stop-1 of one half-frame; lrck toggles with the first bck fall when asked.
  task automatic half(input bit toggle, input logic [23:0] w, input int start, input int stop);
    for (int i = start; i < stop; i++) begin
      bck  = 1'b0;
      data = (i < 24) ? w[23-i] : 1'b0;
      if (toggle && i == start) lrck = ~lrck;
      tick();
      tick();
      bck = 1'b1;
      if (i == 23) rise_cyc = cyc;
      tick();
      tick();
    end
  endtask

  task automatic pulse_clr();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  initial begin
    // Reset
    repeat (16) tick();
    check("rst_wrreq", 32'(fifo_wrreq), 32'd0);
    check("rst_data", fifo_data, 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_ovf", 32'(ovf), 32'd0);
    reset_n = 1'b1;

    // Stream starts mid left word: nothing written for it
    half(1'b0, WL, 10, 32);
    check("partial_no_write", wr_cnt, 0);
    half(1'b1, WR, 0, 32);
    half(1'b1, WL, 0, 32);
    half(1'b1, WR, 0, 32);
    check("basic_count", wr_cnt, 3);
    check("latency", 32'(last_wr_cyc - rise_cyc), 32'd4);
    pop_check("basic_r0", 32'h00123456);
    pop_check("basic_l", 32'h80ABCDEF);
    pop_check("basic_r1", 32'h00123456);
    check("data_hold", fifo_data, 32'h00123456);

    // Left word dropped on fifo_full
    base = wr_cnt;
    fifo_full = 1'b1;
    half(1'b1, WL, 0, 32);
    fifo_full = 1'b0;
    check("full_no_write", wr_cnt, base);
    check("ovf_set", 32'(ovf), 32'd1);
`ifdef LJ24RX_DROP_CNT_EN
    check("drop_cnt_1", 32'(drop_cnt), 32'd1);
`endif
    half(1'b1, WR, 0, 32);
    pop_check("after_full_r", 32'h00123456);
    check("ovf_sticky", 32'(ovf), 32'd1);
`ifdef LJ24RX_DROP_CNT_EN
    fifo_full = 1'b1;
    for (int k = 0; k < 299; k++) half(1'b1, lrck ? WR : WL, 0, 32);
    fifo_full = 1'b0;
    check("drop_cnt_sat", 32'(drop_cnt), 32'hFF);
`endif
    pulse_clr();
    check("ovf_clr", 32'(ovf), 32'd0);
`ifdef LJ24RX_DROP_CNT_EN
    check("drop_cnt_clr", 32'(drop_cnt), 32'd0);
`endif

    // lrck edge after 20 bits: frame error, no write, next frame fine
    check("frame_err_idle", 32'(frame_err), 32'd0);
    base = wr_cnt;
    half(1'b1, lrck ? WR : WL, 0, 20);
    half(1'b1, lrck ? WR : WL, 0, 32);
    check("frame_err_set", 32'(frame_err), 32'd1);
    check("frame_err_one_write", wr_cnt, base + 1);
    pop_check("frame_err_next", lrck ? 32'h80ABCDEF : 32'h00123456);
    pulse_clr();
    check("frame_err_clr", 32'(frame_err), 32'd0);

    // Ramp in order
    for (int k = 0; k < 4; k++) begin
      half(1'b1, 24'd1024 + 24'(k), 0, 32);
      eq.push_back({lrck, 7'd0, 24'd1024 + 24'(k)});
    end
    for (int k = 0; k < 4; k++) pop_check("ramp", eq.pop_front());

    // 48fs frames: exactly 24 bck per half, back to back
    half(1'b1, 24'hF00001, 0, 24);
    eq.push_back({lrck, 7'd0, 24'hF00001});
    half(1'b1, 24'h00000F, 0, 24);
    eq.push_back({lrck, 7'd0, 24'h00000F});
    repeat (8) tick();
    pop_check("fs48_a", eq.pop_front());
    pop_check("fs48_b", eq.pop_front());

    // Reset pulse mid-word: outputs cleared, partial word dropped, next half-frame written
    half(1'b1, 24'h5A5A5A, 0, 10);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("midrst_data", fifo_data, 32'd0);
    check("midrst_wrreq", 32'(fifo_wrreq), 32'd0);
    base = wr_cnt;
    half(1'b0, 24'h5A5A5A, 10, 32);
    check("midrst_no_write", wr_cnt, base);
    half(1'b1, 24'h0C0FFE, 0, 32);
    pop_check("midrst_next", {lrck, 7'd0, 24'h0C0FFE});

    check("no_double_wrreq", 32'(double_wr), 32'd0);
    check("queue_empty", wq.size(), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
